// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

    localparam int RAM_DEPTH = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_ID_IF  = 1'b0,
        ARB_ID_MEM = 1'b1
    } arb_id_t;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - winner selection between IF and MEM requesters (policy set by RAM_ARB_RR_EN)
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    mem_req,
    input  arb_id_t last_id,
    output arb_id_t win_id,
    output logic    win_valid
);

    // Uncontended requests win outright; contention resolved by the compiled-in policy
    always_comb begin
        win_valid = if_req | mem_req;
        win_id    = ARB_ID_IF;
        if (if_req && mem_req) begin
`ifdef RAM_ARB_RR_EN
            win_id = (last_id == ARB_ID_IF) ? ARB_ID_MEM : ARB_ID_IF;
`else
            win_id = ARB_ID_MEM;
`endif
        end else if (mem_req) begin
            win_id = ARB_ID_MEM;
        end
    end

`ifdef RAM_ARB_RR_EN
`else
    // Fixed priority has no history; the port stays for a uniform interface
    logic unused_last_id;
    assign unused_last_id = (last_id == ARB_ID_MEM);
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port (IF read / MEM read-write) arbiter onto one RAM, RAM_ARB_RR_EN selects round-robin
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              arb_err,
    output logic              read_ram,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_out
);

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    arb_state_t        state_q, state_d;
    arb_id_t           win_q, win_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_write_data_q, ram_write_data_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_gnt_q, if_gnt_d, mem_gnt_q, mem_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, mem_rvalid_q, mem_rvalid_d;
    logic              arb_err_q, arb_err_d;
    logic              read_ram_q, read_ram_d, write_ram_q, write_ram_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_we;
    logic              sel_oor;
    logic [31:0]       access_data;

    arb_id_t           pick_id;
    logic              pick_valid;
    arb_id_t           last_win;

`ifdef RAM_ARB_RR_EN
    arb_id_t           last_q, last_d;
    assign last_win = last_q;
`else
    assign last_win = ARB_ID_IF;
`endif

    ram_arb_pick u_pick (
        .if_req    (if_req),
        .mem_req   (mem_req),
        .last_id   (last_win),
        .win_id    (pick_id),
        .win_valid (pick_valid)
    );

    // Next-state and next-output computation; pulse outputs default low each cycle
    always_comb begin
        state_d          = state_q;
        win_d            = win_q;
        we_d             = we_q;
        oor_d            = oor_q;
        ram_addr_d       = ram_addr_q;
        ram_write_data_d = ram_write_data_q;
        if_rdata_d       = if_rdata_q;
        mem_rdata_d      = mem_rdata_q;
        if_gnt_d         = 1'b0;
        mem_gnt_d        = 1'b0;
        if_rvalid_d      = 1'b0;
        mem_rvalid_d     = 1'b0;
        arb_err_d        = 1'b0;
        read_ram_d       = 1'b0;
        write_ram_d      = 1'b0;
        sel_addr         = (pick_id == ARB_ID_MEM) ? mem_addr : if_addr;
        sel_we           = (pick_id == ARB_ID_MEM) ? mem_we : 1'b0;
        sel_wdata        = (pick_id == ARB_ID_MEM) ? mem_wdata : 32'd0;
        sel_oor          = (sel_addr >= DEPTH_LIM);
        // Writes and out-of-range accesses return zero instead of RAM data
        access_data      = (oor_q || we_q) ? 32'd0 : ram_out;
`ifdef RAM_ARB_RR_EN
        last_d           = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d          = ARB_ACCESS;
                    win_d            = pick_id;
                    we_d             = sel_we;
                    oor_d            = sel_oor;
                    ram_addr_d       = sel_addr;
                    ram_write_data_d = sel_wdata;
                    if_gnt_d         = (pick_id == ARB_ID_IF);
                    mem_gnt_d        = (pick_id == ARB_ID_MEM);
                    read_ram_d       = !sel_oor && !sel_we;
                    write_ram_d      = !sel_oor && sel_we;
`ifdef RAM_ARB_RR_EN
                    last_d           = pick_id;
`endif
                end
            end
            ARB_ACCESS: begin
                state_d   = ARB_DONE;
                arb_err_d = oor_q;
                if (win_q == ARB_ID_MEM) begin
                    mem_rdata_d  = access_data;
                    mem_rvalid_d = 1'b1;
                end else begin
                    if_rdata_d   = access_data;
                    if_rvalid_d  = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any in-flight access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ARB_IDLE;
            win_q            <= ARB_ID_IF;
            we_q             <= 1'b0;
            oor_q            <= 1'b0;
            ram_addr_q       <= '0;
            ram_write_data_q <= '0;
            if_rdata_q       <= '0;
            mem_rdata_q      <= '0;
            if_gnt_q         <= 1'b0;
            mem_gnt_q        <= 1'b0;
            if_rvalid_q      <= 1'b0;
            mem_rvalid_q     <= 1'b0;
            arb_err_q        <= 1'b0;
            read_ram_q       <= 1'b0;
            write_ram_q      <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_q           <= ARB_ID_IF;
`endif
        end else begin
            state_q          <= state_d;
            win_q            <= win_d;
            we_q             <= we_d;
            oor_q            <= oor_d;
            ram_addr_q       <= ram_addr_d;
            ram_write_data_q <= ram_write_data_d;
            if_rdata_q       <= if_rdata_d;
            mem_rdata_q      <= mem_rdata_d;
            if_gnt_q         <= if_gnt_d;
            mem_gnt_q        <= mem_gnt_d;
            if_rvalid_q      <= if_rvalid_d;
            mem_rvalid_q     <= mem_rvalid_d;
            arb_err_q        <= arb_err_d;
            read_ram_q       <= read_ram_d;
            write_ram_q      <= write_ram_d;
`ifdef RAM_ARB_RR_EN
            last_q           <= last_d;
`endif
        end
    end

    assign if_gnt         = if_gnt_q;
    assign if_rvalid      = if_rvalid_q;
    assign if_rdata       = if_rdata_q;
    assign mem_gnt        = mem_gnt_q;
    assign mem_rvalid     = mem_rvalid_q;
    assign mem_rdata      = mem_rdata_q;
    assign arb_err        = arb_err_q;
    assign read_ram       = read_ram_q;
    assign write_ram      = write_ram_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_data = ram_write_data_q;

endmodule
